// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with RV32M corner cases.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip the CALC phase.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q, dvnd_raw_q;
   logic [1:0]       op_q;
   logic             neg_quo_q, neg_rem_q, div0_q, ovf_q;

   logic             is_signed, accept, div0, ovf, last_step;
   logic [WIDTH-1:0] abs_dvnd, abs_dvsr;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] quo_fix, rem_fix, fin_val;

   assign is_signed = ~op[0];
   assign accept    = start & ~flush & (state == IDLE);
   assign abs_dvnd  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign abs_dvsr  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
   assign div0      = (divisor == '0);
   assign ovf       = is_signed && (dividend == MIN_NEG) && (divisor == '1);
   assign last_step = (cnt == CNT_W'(WIDTH-1));

   // One restoring step: shift {rem, quo} left and try to subtract the divisor.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvsr_q};

   assign quo_fix = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix = neg_rem_q ? -rem_q : rem_q;

   // Special cases override whatever the iteration produced.
   always_comb begin
      fin_val = op_q[1] ? rem_fix : quo_fix;
      if (div0_q)
         fin_val = op_q[1] ? dvnd_raw_q : '1;
      else if (ovf_q)
         fin_val = op_q[1] ? '0 : MIN_NEG;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
`ifdef DIV_FAST_PATH_EN
                  state_nxt = (div0 || ovf) ? FINISH : CALC;
`else
                  state_nxt = CALC;
`endif
               end
            end
            CALC:    if (last_step) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvsr_q     <= '0;
         dvnd_raw_q <= '0;
         op_q       <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
         valid      <= 1'b0;
         result     <= '0;
      end else begin
         valid <= 1'b0;
         if (accept) begin
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= abs_dvnd;
            dvsr_q     <= abs_dvsr;
            dvnd_raw_q <= dividend;
            op_q       <= op;
            neg_quo_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= is_signed & dividend[WIDTH-1];
            div0_q     <= div0;
            ovf_q      <= ovf;
         end else if (!flush && state == CALC) begin
            cnt <= cnt + 1'b1;
            if (!trial[WIDTH]) begin
               rem_q <= trial[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_q <= rem_sh[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
         end else if (!flush && state == FINISH) begin
            result <= fin_val;
            valid  <= 1'b1;
         end
      end
   end

endmodule
